// File: rtl/operand_forward.sv
// operand_forward: operand forwarding and write-back staging for the dual-issue
// (even/odd) pipeline. Each operand bus is [0:127] data, [128:134] source address.
// Each pipe keeps a DEPTH-stage shadow pipeline of results, and the last stage
// drives the register file write port.
// Optional feature: define OPFWD_STATS_EN to add the fwd_hits counter and port.
module operand_forward #(
    parameter int unsigned DEPTH      = 7,
    parameter int unsigned KILL_DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          flush,
    input  logic [0:134]  opnd_in_ra_0,
    input  logic [0:134]  opnd_in_rb_0,
    input  logic [0:134]  opnd_in_rc_0,
    input  logic [0:134]  opnd_in_ra_1,
    input  logic [0:134]  opnd_in_rb_1,
    input  logic [0:134]  opnd_in_rc_1,
    input  logic          res_valid_0,
    input  logic          res_valid_1,
    input  logic [6:0]    res_addr_0,
    input  logic [6:0]    res_addr_1,
    input  logic [127:0]  res_data_0,
    input  logic [127:0]  res_data_1,
    output logic [0:134]  opnd_out_ra_0,
    output logic [0:134]  opnd_out_rb_0,
    output logic [0:134]  opnd_out_rc_0,
    output logic [0:134]  opnd_out_ra_1,
    output logic [0:134]  opnd_out_rb_1,
    output logic [0:134]  opnd_out_rc_1,
    output logic          wr_en_0,
    output logic          wr_en_1,
    output logic [6:0]    wr_addr_0,
    output logic [6:0]    wr_addr_1,
    output logic [127:0]  wr_data_0,
    output logic [127:0]  wr_data_1,
    output logic          err_wr_conflict
`ifdef OPFWD_STATS_EN
    ,
    output logic [31:0]   fwd_hits
`endif
);

    // Shadow pipeline, indexed [pipe][stage]; stage 0 is youngest
    logic         vld [2][DEPTH];
    logic [6:0]   adr [2][DEPTH];
    logic [127:0] dat [2][DEPTH];

    logic         res_v [2];
    logic [6:0]   res_a [2];
    logic [127:0] res_d [2];

    logic [0:134] in_bus  [6];
    logic [0:134] fwd_bus [6];
    logic [0:134] out_q   [6];
    logic [5:0]   hit;
    logic         conflict;

    // Gather the per-pipe and per-operand ports into arrays
    always_comb begin
        res_v[0]  = res_valid_0;
        res_v[1]  = res_valid_1;
        res_a[0]  = res_addr_0;
        res_a[1]  = res_addr_1;
        res_d[0]  = res_data_0;
        res_d[1]  = res_data_1;
        in_bus[0] = opnd_in_ra_0;
        in_bus[1] = opnd_in_rb_0;
        in_bus[2] = opnd_in_rc_0;
        in_bus[3] = opnd_in_ra_1;
        in_bus[4] = opnd_in_rb_1;
        in_bus[5] = opnd_in_rc_1;
    end

    // Forwarding mux: scan oldest to youngest and pipe 0 before pipe 1, so the
    // last match is the youngest entry, with pipe 1 winning ties at equal age
    always_comb begin
        for (int unsigned j = 0; j < 6; j++) begin
            fwd_bus[j] = in_bus[j];
            hit[j]     = 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                for (int unsigned p = 0; p < 2; p++) begin
                    if (vld[p][DEPTH-1-i] && (adr[p][DEPTH-1-i] == in_bus[j][128:134])) begin
                        fwd_bus[j][0:127] = dat[p][DEPTH-1-i];
                        hit[j]            = 1'b1;
                    end
                end
            end
            for (int unsigned p = 0; p < 2; p++) begin
                if (res_v[p] && (res_a[p] == in_bus[j][128:134])) begin
                    fwd_bus[j][0:127] = res_d[p];
                    hit[j]            = 1'b1;
                end
            end
        end
    end

    // Write-back comes from the oldest stage and is suppressed while stalled or in reset
    always_comb begin
        wr_en_0   = vld[0][DEPTH-1] & ~stall & ~reset;
        wr_en_1   = vld[1][DEPTH-1] & ~stall & ~reset;
        wr_addr_0 = adr[0][DEPTH-1];
        wr_addr_1 = adr[1][DEPTH-1];
        wr_data_0 = dat[0][DEPTH-1];
        wr_data_1 = dat[1][DEPTH-1];
        conflict  = wr_en_0 & wr_en_1 & (wr_addr_0 == wr_addr_1);
        opnd_out_ra_0 = out_q[0];
        opnd_out_rb_0 = out_q[1];
        opnd_out_rc_0 = out_q[2];
        opnd_out_ra_1 = out_q[3];
        opnd_out_rb_1 = out_q[4];
        opnd_out_rc_1 = out_q[5];
    end

    // Shadow pipeline shift, operand registers, flush kill and sticky conflict flag.
    // The flush clear is written after the shift so that it wins on the young stages
    // and also drops the entry that would otherwise enter stage 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned p = 0; p < 2; p++) begin
                for (int unsigned k = 0; k < DEPTH; k++) begin
                    vld[p][k] <= 1'b0;
                    adr[p][k] <= '0;
                    dat[p][k] <= '0;
                end
            end
            for (int unsigned j = 0; j < 6; j++) begin
                out_q[j] <= '0;
            end
            err_wr_conflict <= 1'b0;
        end else begin
            if (!stall) begin
                for (int unsigned p = 0; p < 2; p++) begin
                    for (int unsigned k = 1; k < DEPTH; k++) begin
                        vld[p][k] <= vld[p][k-1];
                        adr[p][k] <= adr[p][k-1];
                        dat[p][k] <= dat[p][k-1];
                    end
                    vld[p][0] <= res_v[p];
                    adr[p][0] <= res_a[p];
                    dat[p][0] <= res_d[p];
                end
                for (int unsigned j = 0; j < 6; j++) begin
                    out_q[j] <= fwd_bus[j];
                end
            end
            if (flush) begin
                for (int unsigned p = 0; p < 2; p++) begin
                    for (int unsigned k = 0; k < KILL_DEPTH; k++) begin
                        vld[p][k] <= 1'b0;
                    end
                end
            end
            if (conflict) begin
                err_wr_conflict <= 1'b1;
            end
        end
    end

`ifdef OPFWD_STATS_EN
    logic [2:0]  hit_cnt;
    logic [32:0] hit_sum;

    // Count the operands that took a forwarded value this cycle
    always_comb begin
        hit_cnt = '0;
        for (int unsigned j = 0; j < 6; j++) begin
            hit_cnt = hit_cnt + {2'b00, hit[j]};
        end
        hit_sum = {1'b0, fwd_hits} + {30'd0, hit_cnt};
    end

    // Saturating forward-hit counter, advanced only on non-stalled cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_hits <= '0;
        end else if (!stall) begin
            fwd_hits <= hit_sum[32] ? '1 : hit_sum[31:0];
        end
    end
`endif

endmodule

// File: doc/operand_forward.md
# operand_forward

Operand forwarding and write-back staging block for the dual-issue (even/odd) pipeline. It sits directly downstream of the 128×128 register file: it takes the six 135-bit operand buses (128-bit data plus 7-bit source address), replaces stale data with in-flight results from either pipe, and registers the corrected operands for the execute stage. It also holds a per-pipe shadow pipeline of results and drives the register file write ports from its final stage.

## Interface
- DEPTH, 7: shadow pipeline stages per pipe, ≥2; stage DEPTH-1 drives write-back.
- KILL_DEPTH, 2: number of youngest stages (0..KILL_DEPTH-1) invalidated by flush; must be < DEPTH.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- stall  in  1  hold all state and outputs; suppress write-back.
- flush  in  1  invalidate the youngest KILL_DEPTH stages of both pipes.
- opnd_in_ra_0/rb_0/rc_0/ra_1/rb_1/rc_1  in  135 each  operand from the register file: [0:127] data, [128:134] source address.
- res_valid_0, res_valid_1  in  1  a result enters stage 0 of pipe 0/1 this cycle.
- res_addr_0, res_addr_1  in  7  destination register.
- res_data_0, res_data_1  in  128  result data.
- opnd_out_ra_0/rb_0/rc_0/ra_1/rb_1/rc_1  out  135 each  forwarded operand; address field passed through unchanged.
- wr_en_0, wr_en_1  out  1  register file write enable for pipe 0/1.
- wr_addr_0, wr_addr_1  out  7  write address.
- wr_data_0, wr_data_1  out  128  write data.
- err_wr_conflict  out  1  sticky: both pipes wrote the same address in the same write-back cycle.
- fwd_hits  out  32  present only under OPFWD_STATS_EN.

## Operation
- Shadow pipeline: per pipe, DEPTH entries of {valid, addr[7], data[128]}. Each non-stalled cycle: stage k → k+1; stage 0 ← {res_valid, res_addr, res_data}; the old stage DEPTH-1 entry is retired.
- Forwarding is evaluated per operand against the current stage contents plus the incoming res_* entries, which count as youngest (age -1). Candidates: every valid entry whose addr equals the operand address field.
- Priority: youngest age wins. At equal age, pipe 1 beats pipe 0. A hit replaces data[0:127]. With no hit, the input data passes through.
- Write-back: wr_en_p = stage[DEPTH-1].valid & ~stall. wr_addr and wr_data are driven from that stage continuously.
- If wr_en_0 & wr_en_1 & (wr_addr_0 == wr_addr_1): set err_wr_conflict. It clears only on reset. Pipe 1 data is architecturally the newer value, consistent with the forwarding priority.
- Flush: clear the valid bits of stages 0..KILL_DEPTH-1 in both pipes, and drop incoming res_* that cycle. Flush takes effect after that cycle's shift. Operands sampled in the flush cycle still see the pre-flush entries.
- Stall: shadow state, opnd_out_* and err flag hold. Incoming res_* and opnd_in_* are ignored. Stall and flush in the same cycle: flush applies, no shift.

## Timing
- Operand latency: 1 cycle. opnd_in sampled at edge N appears on opnd_out after edge N.
- A result presented with res_valid at edge N:
  - is forwardable to operands sampled at edge N;
  - occupies stage k after edge N+k;
  - appears on wr_* after edge N+DEPTH-1, with wr_en high for that one cycle (absent stall).
- Reset (synchronous, priority over stall/flush): all valid bits 0; opnd_out_* = 0; wr_en_* = 0; wr_addr_* = 0; wr_data_* = 0; err_wr_conflict = 0; fwd_hits = 0.
- Reset while results are in flight discards them; no write-back occurs.

## Configuration
- OPFWD_STATS_EN defined: fwd_hits port and counter exist. On each non-stalled cycle the counter increments by the number of operands (0–6) that took a forwarded value, saturating at 0xFFFF_FFFF.
- OPFWD_STATS_EN undefined: no port, no counter logic; all other behaviour is identical.

## Test plan
- Pass-through: no results in flight; opnd_in_ra_0 = {128'hA5.., 7'd3} → opnd_out_ra_0 identical one cycle later; wr_en_* stay 0.
- Age priority: pipe 0 writes r5=1; the next cycle pipe 0 writes r5=2. Then rb_1 reads r5 → data 2. After the first result retires (DEPTH-1 cycles), wr_en_0 pulses with r5=1, then r5=2 the next cycle.
- Same-age tie: pipe 0 and pipe 1 both present r9 (0x11 vs 0x22) while rc_0 reads r9 → 0x22. After DEPTH-1 cycles both wr_en_* assert and err_wr_conflict rises and stays high.
- Flush: result r7 enters; the next cycle flush asserts (KILL_DEPTH=2). A later operand read of r7 → register-file input data, and no wr_en for r7 ever.
- Stall: assert stall for 3 cycles with r4 at stage DEPTH-1 → wr_en_0 low during the stall, opnd_out held; r4 writes on the first cycle after stall drops.
- Reset mid-flight: 3 results in flight, reset 1 cycle → all outputs 0, no later write-back. Under OPFWD_STATS_EN, fwd_hits counts 6 for a cycle where all six operands hit, then returns to 0 on reset.
